alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
Sequential execute unit that consumes the ALU control bundle (Op, Cin, invA, invB, sign) produced by the ALU op decoder, together with two 16-bit operands.
- Add, AND, OR and XOR complete in one cycle.
- Rotates and shifts run iteratively, one bit position per cycle, which removes the barrel shifter from the critical path.
- Sits in the execute stage between decode/regfile operand muxing and memory/writeback.
- Uses a valid/ready handshake on both sides so the pipeline control logic can stall around it.

Parameters:
WIDTH, 16, operand/result width
SHAMT_W, 4, shift-amount width taken from the low bits of effective B

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand bundle valid
in_ready  out  1  unit can accept a bundle
Op  in  3  000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 ADD, 101 AND, 110 OR, 111 XOR
Cin  in  1  adder carry-in
invA  in  1  invert A before the op
invB  in  1  invert B before the op
sign  in  1  1 = signed overflow semantics, 0 = unsigned
InA  in  WIDTH  operand A
InB  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
Out  out  WIDTH  result
Zero  out  1  Out == 0
Ofl  out  1  overflow (ADD only)
Cout  out  1  adder carry-out (ADD only)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Reset values: state IDLE, out_valid=0, Out=0, Zero=0, Ofl=0, Cout=0. in_ready=0 while rst=1.
- Effective operands: Aeff = invA ? ~InA : InA; Beff = invB ? ~InB : InB. Applied for all ops.
- Shift amount: n = Beff[SHAMT_W-1:0].
- States:
  - IDLE: in_ready=1. Acceptance happens when in_valid && in_ready at cycle 0; all inputs are captured then and later input changes are ignored.
    - Non-shift op: compute and register the result, go to DONE. out_valid=1 at cycle 1.
    - Shift op with n=0: Out=Aeff, go to DONE. out_valid at cycle 1.
    - Shift op with n>0: load Aeff into the work register and n into the counter, go to SHIFT.
  - SHIFT: each cycle perform a 1-bit step and decrement the counter. When counter==1, take the last step and go to DONE. out_valid at cycle n+1.
    - ROL: {r[14:0], r[15]}.
    - SLL: {r[14:0], 0}.
    - ROR: {r[0], r[15:1]}.
    - SRL: {0, r[15:1]} (logical).
  - DONE: out_valid=1. Out and flags are held stable until out_ready=1, then go to IDLE.
- Throughput:
  - in_ready=0 in SHIFT and DONE, so no new bundle is accepted in the same cycle as a handoff.
  - Back-to-back throughput for 1-cycle ops is one result every 2 cycles.
- ADD: {Cout, sum} = Aeff + Beff + Cin (17-bit).
  - sign=1: Ofl = (Aeff[15]==Beff[15]) && (sum[15]!=Aeff[15]).
  - sign=0: Ofl = Cout.
- Other ops: Ofl=0, Cout=0, and Cin is ignored. Zero is computed from the final Out for every op.
- Op outside the list cannot occur (the 3-bit space is fully defined).
- Reset in SHIFT or DONE aborts the operation, discards the result and returns to IDLE next cycle.
- out_valid never rises without a prior acceptance and never drops without out_ready.

Decomposition:
- Shared package alu_pkg holds:
  - Op encodings ALU_ROL..ALU_XOR.
  - WIDTH/SHAMT_W defaults.
  - State encoding IDLE/SHIFT/DONE.
- One natural sub-module: alu_add16, a combinational 16-bit adder with cin, sum, cout and signed/unsigned ofl, shared with the branch-compare logic.
- FSM, shift register and counter stay in alu_exec_seq.

Test Plan:
1. ADD sub-mode: InA=5, InB=3, invA=1, Cin=1, sign=1 -> Out=0xFFFE, Ofl=0, Cout=0, Zero=0, out_valid at cycle 1.
2. Signed overflow: InA=0x7FFF, InB=0x0001, ADD, sign=1 -> Out=0x8000, Ofl=1. Repeat with sign=0 -> Ofl=0, Cout=0.
3. Rotate and shift latency:
   - ROL InA=0x8001, InB=4 -> Out=0x0018 at cycle 5, in_ready=0 in cycles 1-5.
   - SRL InA=0x8000, InB=15 -> Out=0x0001 at cycle 16.
   - SLL with InB=0 -> Out=InA at cycle 1.
4. Logic ops:
   - ANDN: InA=0xFF0F, InB=0x00FF, Op=101, invB=1 -> Out=0xFF00.
   - XOR: 0xAAAA ^ 0xAAAA -> Out=0, Zero=1.
5. Backpressure: hold out_ready=0 for 3 cycles after out_valid -> Out/flags stable and in_ready=0. After out_ready=1 -> IDLE next cycle, in_ready=1.
6. Reset mid-op: rst=1 at cycle 3 of ROR with n=10 -> out_valid=0 and outputs 0 the cycle after. After rst drops, a new ADD 1+1 -> Out=2 at cycle 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute unit.
//   ALU_WIDTH / ALU_SHAMT_W : default operand and shift-amount widths
//   alu_op_e                : 3-bit op encoding driven by the ALU op decoder
//   alu_state_e             : execute FSM states
package alu_pkg;

  localparam int unsigned ALU_WIDTH   = 16;
  localparam int unsigned ALU_SHAMT_W = 4;

  typedef enum logic [2:0] {
    ALU_ROL = 3'b000,
    ALU_SLL = 3'b001,
    ALU_ROR = 3'b010,
    ALU_SRL = 3'b011,
    ALU_ADD = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } alu_state_e;

  // Rotates and shifts occupy the lower half of the op space.
  function automatic logic is_shift_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/alu_add16.sv
// Combinational adder with carry-in, carry-out and overflow.
// Also used by the branch-compare logic.
//   a_i, b_i : operands
//   cin_i    : carry-in
//   sign_i   : 1 = two's-complement overflow, 0 = unsigned overflow (carry-out)
//   sum_o    : a_i + b_i + cin_i, truncated to WIDTH
//   cout_o   : carry-out of the MSB
//   ofl_o    : overflow under the selected semantics
module alu_add16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ofl_o
);

  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    // Signed overflow: operands agree in sign but the result does not.
    ofl_o = sign_i ? ((a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]))
                   : cout_o;
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential execute unit. ADD/AND/OR/XOR finish in one cycle; rotates and
// shifts step one bit per cycle to keep a barrel shifter off the critical path.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand bundle handshake (accepted only in idle)
//   Op, Cin, invA, invB, sign : decoded ALU control bundle
//   InA, InB            : operands
//   out_valid/out_ready : result handshake; result held until consumed
//   Out, Zero, Ofl, Cout: registered result and flags
module alu_exec_seq import alu_pkg::*; #(
  parameter int unsigned WIDTH   = ALU_WIDTH,
  parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Op,
  input  logic             Cin,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Ofl,
  output logic             Cout
);

  localparam logic [SHAMT_W-1:0] CntOne = SHAMT_W'(1);

  alu_state_e         state_q;
  alu_op_e            op_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic [WIDTH-1:0]   a_eff, b_eff, add_sum, imm_res, step_res;
  logic [SHAMT_W-1:0] shamt;
  logic               add_cout, add_ofl, is_add;

  assign a_eff    = invA ? ~InA : InA;
  assign b_eff    = invB ? ~InB : InB;
  assign shamt    = b_eff[SHAMT_W-1:0];
  assign is_add   = (alu_op_e'(Op) == ALU_ADD);
  assign in_ready = (state_q == StIdle) && !rst;

  alu_add16 #(
    .WIDTH(WIDTH)
  ) u_add (
    .a_i   (a_eff),
    .b_i   (b_eff),
    .cin_i (Cin),
    .sign_i(sign),
    .sum_o (add_sum),
    .cout_o(add_cout),
    .ofl_o (add_ofl)
  );

  // Single-cycle result; shifts land here only when the amount is zero.
  always_comb begin
    imm_res = a_eff;
    unique case (alu_op_e'(Op))
      ALU_ADD: imm_res = add_sum;
      ALU_AND: imm_res = a_eff & b_eff;
      ALU_OR:  imm_res = a_eff | b_eff;
      ALU_XOR: imm_res = a_eff ^ b_eff;
      default: imm_res = a_eff;
    endcase
  end

  // One-bit step of the captured shift op.
  always_comb begin
    step_res = work_q;
    unique case (op_q)
      ALU_ROL: step_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      ALU_SLL: step_res = {work_q[WIDTH-2:0], 1'b0};
      ALU_ROR: step_res = {work_q[0], work_q[WIDTH-1:1]};
      ALU_SRL: step_res = {1'b0, work_q[WIDTH-1:1]};
      default: step_res = work_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= ALU_ROL;
      work_q    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      Out       <= '0;
      Zero      <= 1'b0;
      Ofl       <= 1'b0;
      Cout      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (is_shift_op(Op) && (shamt != '0)) begin
              work_q  <= a_eff;
              cnt_q   <= shamt;
              op_q    <= alu_op_e'(Op);
              state_q <= StShift;
            end else begin
              Out       <= imm_res;
              Zero      <= (imm_res == '0);
              Ofl       <= is_add & add_ofl;
              Cout      <= is_add & add_cout;
              out_valid <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StShift: begin
          work_q <= step_res;
          cnt_q  <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            Out       <= step_res;
            Zero      <= (step_res == '0);
            Ofl       <= 1'b0;
            Cout      <= 1'b0;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed cases with literal results,
// then randomized traffic checked every cycle against a cycle-level model.
module tb_alu_exec_seq;

  typedef struct packed {
    logic [15:0] out;
    logic        zero;
    logic        ofl;
    logic        cout;
  } res_t;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  Op;
  logic        Cin, invA, invB, sign;
  logic [15:0] InA, InB, Out;
  logic        Zero, Ofl, Cout;

  int total = 0;
  int bad   = 0;
  logic checking = 1'b0;

  alu_exec_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Op       (Op),
    .Cin      (Cin),
    .invA     (invA),
    .invB     (invB),
    .sign     (sign),
    .InA      (InA),
    .InB      (InB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out      (Out),
    .Zero     (Zero),
    .Ofl      (Ofl),
    .Cout     (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Result from the arithmetic definition of each op.
  function automatic res_t model_fn(input logic [2:0] op, input logic cin, input logic ia,
                                    input logic ib, input logic sg,
                                    input logic [15:0] a, input logic [15:0] b);
    res_t r;
    logic [15:0] ae, be;
    int k, u, s;
    ae = ia ? ~a : a;
    be = ib ? ~b : b;
    k  = int'(be[3:0]);
    r  = '0;
    case (op)
      3'd0: r.out = (ae << k) | (ae >> (16 - k));
      3'd1: r.out = ae << k;
      3'd2: r.out = (ae >> k) | (ae << (16 - k));
      3'd3: r.out = ae >> k;
      3'd4: begin
        u = int'(ae) + int'(be) + int'(cin);
        s = int'($signed(ae)) + int'($signed(be)) + int'(cin);
        r.out  = u[15:0];
        r.cout = (u > 65535);
        r.ofl  = sg ? ((s > 32767) || (s < -32768)) : r.cout;
      end
      3'd5: r.out = ae & be;
      3'd6: r.out = ae | be;
      default: r.out = ae ^ be;
    endcase
    r.zero = (r.out == 16'h0);
    return r;
  endfunction

  // Cycles from acceptance until the result appears, minus one.
  function automatic int model_lat(input logic [2:0] op, input logic ib, input logic [15:0] b);
    logic [15:0] be;
    be = ib ? ~b : b;
    return (op < 3'd4) ? int'(be[3:0]) : 0;
  endfunction

  // Cycle-level model of the handshake, updated on the same edges as the DUT.
  logic m_idle, m_valid, m_show;
  int   m_wait;
  res_t m_res, m_pend;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0; m_res = '0; m_show = 1'b1;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0;
        m_wait = model_lat(Op, invB, InB);
        m_pend = model_fn(Op, Cin, invA, invB, sign, InA, InB);
        if (m_wait == 0) begin
          m_valid = 1'b1; m_res = m_pend; m_show = 1'b1;
        end
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_res = m_pend; m_show = 1'b1;
      end
    end else if (out_ready) begin
      m_valid = 1'b0; m_idle = 1'b1; m_show = 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (checking) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_idle && !rst});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_show) begin
        chk("Out", {16'b0, Out}, {16'b0, m_res.out});
        chk("flags", {29'b0, Zero, Ofl, Cout}, {29'b0, m_res.zero, m_res.ofl, m_res.cout});
      end
    end
  end

  task automatic scramble();
    Op = 3'($urandom); Cin = 1'($urandom); invA = 1'($urandom); invB = 1'($urandom);
    sign = 1'($urandom); InA = 16'($urandom); InB = 16'($urandom);
  endtask

  task automatic send(input logic [2:0] op, input logic cin, input logic ia, input logic ib,
                      input logic sg, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", {31'b0, in_ready}, 32'd1);
    Op = op; Cin = cin; invA = ia; invB = ib; sign = sg; InA = a; InB = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  // Called in cycle 1 after acceptance.
  task automatic expect_res(input string name, input int lat, input logic [15:0] eo,
                            input logic ez, input logic eofl, input logic ec, input int hold);
    int cyc = 1;
    while (!out_valid && cyc < 40) begin
      chk({name, "_busy_rdy"}, {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk({name, "_lat"}, cyc, lat);
    chk({name, "_out"}, {16'b0, Out}, {16'b0, eo});
    chk({name, "_flags"}, {29'b0, Zero, Ofl, Cout}, {29'b0, ez, eofl, ec});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_out"}, {16'b0, Out}, {16'b0, eo});
      chk({name, "_hold_flags"}, {29'b0, Zero, Ofl, Cout}, {29'b0, ez, eofl, ec});
      chk({name, "_hold_vld"}, {31'b0, out_valid}, 32'd1);
      chk({name, "_hold_rdy"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_rel_rdy"}, {31'b0, in_ready}, 32'd1);
    chk({name, "_rel_vld"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("rst_rdy", {31'b0, in_ready}, 32'd0);
    chk("rst_out", {12'b0, Out, out_valid, Zero, Ofl, Cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD as subtract-style: ~5 + 3 + 1, with 3 cycles of backpressure.
    send(3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 16'd5, 16'd3);
    expect_res("add_sub", 1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 3);
    send(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 16'h0001);
    expect_res("add_sofl", 1, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    send(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
    expect_res("add_uofl", 1, 16'h8000, 1'b0, 1'b0, 1'b0, 0);
    send(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
    expect_res("add_carry", 1, 16'h0000, 1'b1, 1'b1, 1'b1, 0);
    send(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8001, 16'd4);
    expect_res("rol4", 5, 16'h0018, 1'b0, 1'b0, 1'b0, 0);
    send(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 16'd15);
    expect_res("srl15", 16, 16'h0001, 1'b0, 1'b0, 1'b0, 0);
    send(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'd0);
    expect_res("sll0", 1, 16'h1234, 1'b0, 1'b0, 1'b0, 0);
    send(3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFF0F, 16'h00FF);
    expect_res("andn", 1, 16'hFF00, 1'b0, 1'b0, 1'b0, 0);
    send(3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'hAAAA);
    expect_res("xor0", 1, 16'h0000, 1'b1, 1'b0, 1'b0, 0);

    // Reset in cycle 3 of a 10-step rotate.
    send(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'd10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_vld", {31'b0, out_valid}, 32'd0);
    chk("abort_out", {12'b0, Out, Zero, Ofl, Cout}, 32'd0);
    chk("abort_rdy", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1);
    expect_res("post_rst", 1, 16'h0002, 1'b0, 1'b0, 1'b0, 0);

    // Randomized traffic; the compare process does all checking here.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      scramble();
      if ($urandom_range(0, 3) == 0) InB[3:0] = 4'h0;
      @(negedge clk);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drain_rdy", {31'b0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
